// File: rtl/lives_controller.sv
// rtl/lives_controller.sv - player lives, death animation and respawn invulnerability FSM (optional blink: INVULN_BLINK_EN)
module lives_controller #(
  parameter int LIVES_INIT    = 3,
  parameter int DYING_FRAMES  = 60,
  parameter int INVULN_FRAMES = 120
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_tick,
  input  logic [1:0] gameState,
  input  logic       hit,
  output logic [2:0] lives,
  output logic       playerDead,
  output logic       player_active,
  output logic       invuln,
  output logic       player_visible
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ALIVE  = 3'd1,
    DYING  = 3'd2,
    INVULN = 3'd3,
    OUT    = 3'd4
  } state_t;

  localparam logic [1:0] GS_PLAY     = 2'b01;
  localparam logic [7:0] DYING_LAST  = 8'(DYING_FRAMES - 1);
  localparam logic [7:0] INVULN_LAST = 8'(INVULN_FRAMES - 1);
  localparam logic [2:0] LIVES_LOAD  = 3'(LIVES_INIT);

  state_t     state;
  state_t     state_nxt;
  logic [7:0] count;
  logic [7:0] count_nxt;
  logic [2:0] lives_nxt;
  logic       invuln_vis;

  // Visibility while invulnerable: blink on bit 2 of the frame count, or steady on
`ifdef INVULN_BLINK_EN
  assign invuln_vis = ~count_nxt[2];
`else
  assign invuln_vis = 1'b1;
`endif

  // Next-state logic; leaving Play overrides everything, including a same-cycle hit
  always_comb begin
    state_nxt = state;
    count_nxt = count;
    lives_nxt = lives;
    if (gameState != GS_PLAY) begin
      state_nxt = IDLE;
      count_nxt = '0;
    end else begin
      case (state)
        IDLE: begin
          lives_nxt = LIVES_LOAD;
          state_nxt = INVULN;
          count_nxt = '0;
        end
        ALIVE: begin
          // The counter is idle in ALIVE, so a tick coinciding with a hit is never counted
          count_nxt = '0;
          if (hit) begin
            state_nxt = DYING;
            lives_nxt = (lives != 3'd0) ? lives - 3'd1 : 3'd0;
          end
        end
        DYING: begin
          if (frame_tick) begin
            if (count == DYING_LAST) begin
              count_nxt = '0;
              state_nxt = (lives == 3'd0) ? OUT : INVULN;
            end else begin
              count_nxt = count + 8'd1;
            end
          end
        end
        INVULN: begin
          if (frame_tick) begin
            if (count == INVULN_LAST) begin
              count_nxt = '0;
              state_nxt = ALIVE;
            end else begin
              count_nxt = count + 8'd1;
            end
          end
        end
        OUT: begin
          count_nxt = '0;
        end
        default: begin
          state_nxt = IDLE;
          count_nxt = '0;
        end
      endcase
    end
  end

  // State, counter, lives and all outputs registered together so they change on the same edge
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state          <= IDLE;
      count          <= '0;
      lives          <= '0;
      playerDead     <= 1'b0;
      player_active  <= 1'b0;
      invuln         <= 1'b0;
      player_visible <= 1'b0;
    end else begin
      state          <= state_nxt;
      count          <= count_nxt;
      lives          <= lives_nxt;
      playerDead     <= (state_nxt == OUT);
      player_active  <= (state_nxt == ALIVE) || (state_nxt == INVULN);
      invuln         <= (state_nxt == INVULN);
      player_visible <= (state_nxt == ALIVE) || ((state_nxt == INVULN) && invuln_vis);
    end
  end

endmodule

// File: doc/lives_controller.md
LIVES_CONTROLLER -- requirements
Module: lives_controller

Interface
REQ-001 Parameter LIVES_INIT, default 3: lives loaded on entry to Play; range 1..7.
REQ-002 Parameter DYING_FRAMES, default 60: frames spent in death animation before respawn or game over.
REQ-003 Parameter INVULN_FRAMES, default 120: frames of post-respawn invulnerability.
REQ-004 Clk  input  1  system clock; all state changes on rising edge.
REQ-005 Reset  input  1  asynchronous, active-high reset.
REQ-006 frame_tick  input  1  one-Clk pulse per video frame (vsync derived).
REQ-007 gameState  input  2  game controller state: 00 Start, 01 Play, 10 GameOver.
REQ-008 hit  input  1  player-collision pulse from collision logic.
REQ-009 lives  output  3  remaining lives, including the current one.
REQ-010 playerDead  output  1  level to game controller; high means no lives left.
REQ-011 player_active  output  1  player may move and fire (ALIVE or INVULN only).
REQ-012 invuln  output  1  high while in INVULN.
REQ-013 player_visible  output  1  sprite enable for the player renderer.

Function
REQ-014 FSM states SHALL be IDLE, ALIVE, DYING, INVULN, OUT; the frame counter SHALL be 8 bits and count frame_tick pulses only.
REQ-015 Any cycle with gameState != 01 SHALL force IDLE on the next edge and clear the counter; lives SHALL hold their value.
REQ-016 IDLE with gameState == 01 SHALL load lives = LIVES_INIT and enter INVULN with the counter at 0, so each game starts protected.
REQ-017 ALIVE with hit = 1 SHALL enter DYING, decrement lives by 1 (saturating at 0), and clear the counter, all on the same edge.
REQ-018 DYING SHALL last exactly DYING_FRAMES frame_tick pulses; on the pulse that reaches the count, it SHALL go to OUT if lives == 0, else to INVULN with the counter cleared.
REQ-019 INVULN SHALL last exactly INVULN_FRAMES frame_tick pulses, then go to ALIVE.
REQ-020 hit SHALL be ignored in IDLE, DYING, INVULN and OUT.
REQ-021 OUT SHALL hold until gameState != 01; playerDead = 1 only in OUT.
REQ-022 hit and frame_tick in the same cycle in ALIVE: hit wins, and that tick is not counted.
REQ-023 gameState leaving 01 on the same cycle as hit: the gameState rule wins and lives are not decremented.
REQ-024 Outputs SHALL be registered or decoded only from registered state, giving 1-cycle latency from input to output.
REQ-025 player_visible SHALL be 0 in IDLE, DYING and OUT; 1 in ALIVE; in INVULN it SHALL follow REQ-029.

Reset
REQ-026 Reset = 1 SHALL asynchronously force IDLE, counter = 0, lives = 0, playerDead = 0, player_active = 0, invuln = 0 and player_visible = 0.
REQ-027 After Reset deasserts, operation SHALL resume from IDLE per REQ-016; a reset in mid-DYING SHALL leave no residual count.

Configuration
REQ-028 Macro INVULN_BLINK_EN SHALL control the invulnerability blink.
REQ-029 With INVULN_BLINK_EN defined, player_visible in INVULN SHALL equal NOT counter[2], toggling every 4 frames and starting visible. Without it, player_visible SHALL be 1 throughout INVULN.

Verification
REQ-030 Reset pulse, then gameState = 01 -> lives = 3, invuln = 1; after 120 frame_ticks, ALIVE with invuln = 0 and player_active = 1.
REQ-031 ALIVE with lives 3: one hit pulse -> lives = 2, player_visible = 0; after 60 ticks -> invuln = 1, and hit pulses during INVULN leave lives = 2.
REQ-032 Three hits, each after full respawn -> after the third DYING period, playerDead = 1 and lives = 0; gameState = 10 -> IDLE, playerDead = 0; gameState = 01 -> lives = 3.
REQ-033 hit and frame_tick together in ALIVE -> DYING is entered and the counter reads 0 on the next cycle.
REQ-034 gameState forced to 00 at tick 30 of DYING -> IDLE on the next edge with lives unchanged; re-entering 01 reloads lives = 3.
REQ-035 With INVULN_BLINK_EN defined, player_visible pattern over the first 16 INVULN ticks = 1111000011110000; without the macro, constant 1.
